// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the RISC-V datapath.
// Optional feature macro: CTRL_BRANCH_EN (adds BEQ through EXEC with PC redirect on Zero).
module multicycle_controller #(
    parameter int OPCODE_W  = 7,
    parameter int ALUOP_W   = 2,
    parameter int TIMEOUT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                IRWrite,
    output logic                PCSrc,
    output logic                ALUSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                illegal,
    output logic                timeout,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [OPCODE_W-1:0]  OP_R     = 7'b0110011;
    localparam logic [OPCODE_W-1:0]  OP_I     = 7'b0010011;
    localparam logic [OPCODE_W-1:0]  OP_LD    = 7'b0000011;
    localparam logic [OPCODE_W-1:0]  OP_ST    = 7'b0100011;
    localparam logic [OPCODE_W-1:0]  OP_BR    = 7'b1100011;
    localparam logic [TIMEOUT_W-1:0] MAX_WAIT = '1;

    state_t               state_reg, state_next;
    logic [OPCODE_W-1:0]  op_reg, op_next;
    logic [TIMEOUT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic                 illegal_reg, illegal_next;
    logic                 timeout_reg, timeout_next;

    logic       fetch_reg, fetch_next;
    logic       branch_reg, branch_next;
    logic       mem_read_reg, mem_read_next;
    logic       mem_write_reg, mem_write_next;
    logic       alu_src_reg, alu_src_next;
    logic [1:0] alu_op_reg, alu_op_next;
    logic       mem_to_reg_reg, mem_to_reg_next;
    logic       reg_write_reg, reg_write_next;

    logic op_is_ld, op_is_st, op_is_br, wait_expired;

    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        logic ok;
        ok = (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST);
`ifdef CTRL_BRANCH_EN
        ok = ok || (op == OP_BR);
`endif
        return ok;
    endfunction

    assign op_is_ld = (op_reg == OP_LD);
    assign op_is_st = (op_reg == OP_ST);
`ifdef CTRL_BRANCH_EN
    assign op_is_br = (op_reg == OP_BR);
`else
    assign op_is_br = 1'b0;
`endif
    assign wait_expired = !mem_ready && (wait_cnt_reg == MAX_WAIT);

    // Next-state logic; the wait counter is zero outside a stalled FETCH/MEM,
    // so every entry into FETCH or MEM starts counting from zero.
    always_comb begin
        state_next    = state_reg;
        op_next       = op_reg;
        wait_cnt_next = '0;
        illegal_next  = illegal_reg;
        timeout_next  = timeout_reg;
        case (state_reg)
            S_IDLE: if (start) state_next = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (wait_expired) begin
                    state_next   = S_ERR;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_DECODE: begin
                op_next = Opcode;
                if (is_legal(Opcode)) begin
                    state_next = S_EXEC;
                end else begin
                    state_next   = S_ERR;
                    illegal_next = 1'b1;
                end
            end
            S_EXEC: begin
                if (op_is_ld || op_is_st) state_next = S_MEM;
                else if (op_is_br)        state_next = start ? S_FETCH : S_IDLE;
                else                      state_next = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_is_ld) state_next = S_WB;
                    else          state_next = start ? S_FETCH : S_IDLE;
                end else if (wait_expired) begin
                    state_next   = S_ERR;
                    timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            S_WB:    state_next = start ? S_FETCH : S_IDLE;
            S_ERR:   state_next = S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the upcoming state so the registered copies
    // line up exactly with the state they belong to.
    always_comb begin
        fetch_next      = (state_next == S_FETCH);
        branch_next     = 1'b0;
        mem_read_next   = (state_next == S_FETCH) ||
                          ((state_next == S_MEM) && (op_next == OP_LD));
        mem_write_next  = (state_next == S_MEM) && (op_next == OP_ST);
        alu_src_next    = 1'b0;
        alu_op_next     = 2'b00;
        mem_to_reg_next = (state_next == S_WB) && (op_next == OP_LD);
        reg_write_next  = (state_next == S_WB);
        if (state_next == S_EXEC) begin
            if (op_next == OP_R) begin
                alu_op_next = 2'b10;
            end else if ((op_next == OP_LD) || (op_next == OP_ST)) begin
                alu_src_next = 1'b1;
                alu_op_next  = 2'b01;
            end else if (op_next == OP_I) begin
                alu_src_next = 1'b1;
            end
`ifdef CTRL_BRANCH_EN
            else if (op_next == OP_BR) begin
                alu_op_next = 2'b11;
                branch_next = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            op_reg         <= '0;
            wait_cnt_reg   <= '0;
            illegal_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
            fetch_reg      <= 1'b0;
            branch_reg     <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            alu_src_reg    <= 1'b0;
            alu_op_reg     <= 2'b00;
            mem_to_reg_reg <= 1'b0;
            reg_write_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            wait_cnt_reg   <= wait_cnt_next;
            illegal_reg    <= illegal_next;
            timeout_reg    <= timeout_next;
            fetch_reg      <= fetch_next;
            branch_reg     <= branch_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            alu_src_reg    <= alu_src_next;
            alu_op_reg     <= alu_op_next;
            mem_to_reg_reg <= mem_to_reg_next;
            reg_write_reg  <= reg_write_next;
        end
    end

    assign IRWrite = fetch_reg && mem_ready;
`ifdef CTRL_BRANCH_EN
    assign PCWrite = (fetch_reg && mem_ready) || (branch_reg && Zero);
    assign PCSrc   = branch_reg;
`else
    logic unused_branch;
    assign unused_branch = Zero ^ branch_reg;
    assign PCWrite = fetch_reg && mem_ready;
    assign PCSrc   = 1'b0;
`endif
    assign ALUSrc   = alu_src_reg;
    assign ALUOp    = ALUOP_W'(alu_op_reg);
    assign MemRead  = mem_read_reg;
    assign MemWrite = mem_write_reg;
    assign MemtoReg = mem_to_reg_reg;
    assign RegWrite = reg_write_reg;
    assign illegal  = illegal_reg;
    assign timeout  = timeout_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller (TIMEOUT_W=2), plus hand-written
// reset-mid-MEM and latency sequences. Honours CTRL_BRANCH_EN if defined.
module tb_multicycle_controller;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset, start, Zero, mem_ready;
    logic [6:0] Opcode;
    logic       PCWrite, IRWrite, PCSrc, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite;
    logic       illegal, timeout;
    logic [1:0] ALUOp;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // exp = {state, PCWrite, IRWrite, PCSrc, ALUSrc, ALUOp, MemRead, MemWrite, MemtoReg, RegWrite, illegal, timeout}
    typedef struct {
        string       name;
        logic        rst;
        logic        start;
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[$];

    multicycle_controller #(.OPCODE_W(7), .ALUOP_W(2), .TIMEOUT_W(2)) dut (
        .clk(clk), .reset(reset), .start(start), .Opcode(Opcode), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite), .PCSrc(PCSrc),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal(illegal), .timeout(timeout),
        .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic add(input string n, input logic r, input logic s, input logic [6:0] op,
                       input logic z, input logic rdy, input logic [2:0] st,
                       input logic pcw, input logic irw, input logic pcs, input logic asrc,
                       input logic [1:0] aop, input logic mr, input logic mw, input logic m2r,
                       input logic rw, input logic ill, input logic to);
        vec_t v;
        v.name = n; v.rst = r; v.start = s; v.op = op; v.zero = z; v.rdy = rdy;
        v.exp = {st, pcw, irw, pcs, asrc, aop, mr, mw, m2r, rw, ill, to};
        vecs.push_back(v);
    endtask

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end else begin
            $display("ok   %s: %0h", n, got);
        end
    endtask

    function automatic logic [14:0] snap();
        return {state, PCWrite, IRWrite, PCSrc, ALUSrc, ALUOp, MemRead, MemWrite,
                MemtoReg, RegWrite, illegal, timeout};
    endfunction

    // Cycles from one FETCH entry to the next with mem_ready and start held high.
    task automatic measure(input string n, input logic [6:0] op, input int exp_lat);
        int cnt;
        Opcode = op; start = 1'b1; mem_ready = 1'b1; Zero = 1'b0;
        cnt = 0;
        while (state != 3'd1 && cnt < 20) begin
            @(negedge clk); cnt++;
        end
        cnt = 0;
        do begin
            @(negedge clk); cnt++;
        end while (state != 3'd1 && cnt < 20);
        check(n, cnt, exp_lat);
    endtask

    initial begin
        //   name          rst s  op      z  rdy  st pcw irw pcs as aop  mr mw m2r rw ill to
        add("reset",        1, 0, OP_R,   0, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("r_idle",       0, 1, OP_R,   0, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("r_fetch",      0, 1, OP_R,   0, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("r_decode",     0, 1, OP_R,   0, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("r_exec",       0, 1, OP_R,   0, 1,   3, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
        add("r_wb",         0, 1, OP_I,   0, 1,   5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        add("i_fetch",      0, 1, OP_I,   0, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("i_decode",     0, 1, OP_I,   0, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("i_exec",       0, 1, OP_I,   0, 1,   3, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0, 0);
        add("i_wb",         0, 1, OP_LD,  0, 1,   5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        add("ld_fetch",     0, 1, OP_LD,  0, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("ld_decode",    0, 1, OP_LD,  0, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("ld_exec",      0, 1, OP_LD,  0, 0,   3, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0);
        add("ld_mem0",      0, 1, OP_LD,  0, 0,   4, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("ld_mem1",      0, 1, OP_LD,  0, 0,   4, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("ld_mem2",      0, 1, OP_LD,  0, 1,   4, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("ld_wb",        0, 1, OP_ST,  0, 1,   5, 0, 0, 0, 0, 2'b00, 0, 0, 1, 1, 0, 0);
        add("st_fetch",     0, 1, OP_ST,  0, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("st_decode",    0, 1, OP_ST,  0, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("st_exec",      0, 1, OP_ST,  0, 1,   3, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0);
        add("st_mem",       0, 0, OP_ST,  0, 1,   4, 0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 0);
        add("st_idle",      0, 0, OP_ST,  0, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("idle_go",      0, 1, OP_BAD, 0, 0,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("rdy4_f0",      0, 1, OP_BAD, 0, 0,   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("rdy4_f1",      0, 1, OP_BAD, 0, 0,   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("rdy4_f2",      0, 1, OP_BAD, 0, 0,   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("rdy4_f3",      0, 1, OP_BAD, 0, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("bad_decode",   0, 1, OP_BAD, 0, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("err_hold0",    0, 1, OP_R,   1, 1,   6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        add("err_hold1",    0, 1, OP_R,   1, 0,   6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        add("err_reset",    1, 1, OP_R,   0, 0,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("to_idle",      0, 1, OP_R,   0, 0,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("to_f0",        0, 1, OP_R,   0, 0,   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("to_f1",        0, 1, OP_R,   0, 0,   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("to_f2",        0, 1, OP_R,   0, 0,   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("to_f3",        0, 1, OP_R,   0, 0,   1, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("to_err",       0, 1, OP_R,   0, 1,   6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
        add("to_reset",     1, 1, OP_R,   0, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("br_idle",      0, 1, OP_BR,  1, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("br_fetch",     0, 1, OP_BR,  1, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("br_decode",    0, 1, OP_BR,  1, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
`ifdef CTRL_BRANCH_EN
        add("br_exec_z1",   0, 1, OP_BR,  1, 1,   3, 1, 0, 1, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        add("br_fetch2",    0, 1, OP_BR,  0, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("br_decode2",   0, 1, OP_BR,  0, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("br_exec_z0",   0, 0, OP_BR,  0, 1,   3, 0, 0, 1, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        add("br_idle2",     0, 0, OP_BR,  0, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
`else
        add("br_err",       0, 1, OP_BR,  1, 1,   6, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0);
        add("br_reset",     1, 1, OP_BR,  1, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
`endif
        add("sd_idle",      0, 1, OP_R,   0, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("sd_fetch",     0, 1, OP_R,   0, 1,   1, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0);
        add("sd_decode",    0, 0, OP_R,   0, 1,   2, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        add("sd_exec",      0, 0, OP_R,   0, 1,   3, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0);
        add("sd_wb",        0, 0, OP_R,   0, 1,   5, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
        add("sd_end",       0, 0, OP_R,   0, 1,   0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

        reset = 1'b1; start = 1'b0; Opcode = OP_R; Zero = 1'b0; mem_ready = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            reset = vecs[i].rst; start = vecs[i].start; Opcode = vecs[i].op;
            Zero = vecs[i].zero; mem_ready = vecs[i].rdy;
            #1;
            check(vecs[i].name, 32'(snap()), 32'(vecs[i].exp));
        end

        // Store stalled in MEM, then reset asserted between clock edges.
        @(negedge clk); reset = 1'b0; start = 1'b1; mem_ready = 1'b1; Opcode = OP_ST;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); #1;
        check("mid_mem_write", 32'({state, MemWrite}), 32'({3'd4, 1'b1}));
        #2 reset = 1'b1;
        #1 check("mid_mem_reset", 32'({state, MemWrite, MemRead, RegWrite}), 32'd0);
        @(negedge clk); reset = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        check("post_reset_idle", 32'({state, RegWrite}), 32'd0);

        measure("lat_r",  OP_R,  4);
        measure("lat_ld", OP_LD, 5);
        measure("lat_st", OP_ST, 4);
        measure("lat_i",  OP_I,  4);
`ifdef CTRL_BRANCH_EN
        measure("lat_br", OP_BR, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
